// File: rtl/gf_divider.sv
// Sequential GF(2^8) divider over the AES field (x^8+x^4+x^3+x+1).
// quotient = dividend * divisor^254, with the power built by square-and-multiply.
module gf_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {IDLE, EXP, MUL} state_t;

    state_t     state_reg, state_next;
    logic [7:0] a_reg;
    logic [7:0] sq;
    logic [7:0] acc;
    logic [2:0] cnt;
    logic       dz;

    logic [7:0] sq_sq;
    logic [7:0] acc_mul;
    logic [7:0] quot_mul;

    // Shift-and-add multiply; the running multiplicand is reduced by 0x1B
    // each time it overflows x^7, so no wide product is ever formed.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    assign sq_sq    = gf_mul(sq, sq);
    assign acc_mul  = gf_mul(acc, sq_sq);
    assign quot_mul = gf_mul(acc, a_reg);
    assign busy     = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = EXP;
            EXP:     if (cnt == 3'd6) state_next = MUL;
            MUL:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= 8'h00;
            sq          <= 8'h00;
            acc         <= 8'h01;
            cnt         <= 3'd0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= 8'h00;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg <= dividend;
                        sq    <= divisor;
                        acc   <= 8'h01;
                        cnt   <= 3'd0;
                        dz    <= (divisor == 8'h00);
                    end
                end
                EXP: begin
                    // After seven steps acc holds divisor^(2+4+...+128) = divisor^254.
                    sq  <= sq_sq;
                    acc <= acc_mul;
                    cnt <= cnt + 3'd1;
                end
                MUL: begin
                    quotient    <= quot_mul;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_divider.sv
// Bench for gf_divider: directed table, multi-cycle corner sequences,
// randomized operations against a search-based reference, and a back-to-back inverse sweep.
module tb_gf_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic       div_by_zero;

    int vectors;
    int miscompares;

    gf_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] q;
        logic       dz;
    } vec_t;

    vec_t tbl [6];

    // Reference multiply: full carry-less product, then long division by 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (15'({7'h0, x}) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Reference quotient: the unique q with q*d == a, found by search.
    function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = 8'h00;
        if (d != 8'h00) begin
            for (int q = 0; q < 256; q++)
                if (ref_mul(8'(q), d) == a) r = 8'(q);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One operation with a single-cycle start pulse; returns result and edges to done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] q, output logic dzo, output int lat);
        dividend = a;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        q   = 8'hxx;
        dzo = 1'bx;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                q   = quotient;
                dzo = div_by_zero;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] q;
        logic       dzo;
        int         lat;
        int         done_cnt;
        int         done_at;
        logic       busy_ok;
        logic [7:0] q_seen;

        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        dividend    = 8'h00;
        divisor     = 8'h00;

        tbl[0] = '{a: 8'h01, d: 8'h53, q: 8'hCA, dz: 1'b0};
        tbl[1] = '{a: 8'hC1, d: 8'h83, q: 8'h57, dz: 1'b0};
        tbl[2] = '{a: 8'h57, d: 8'h01, q: 8'h57, dz: 1'b0};
        tbl[3] = '{a: 8'h3C, d: 8'h00, q: 8'h00, dz: 1'b1};
        tbl[4] = '{a: 8'h00, d: 8'h05, q: 8'h00, dz: 1'b0};
        tbl[5] = '{a: 8'h01, d: 8'h02, q: 8'h8D, dz: 1'b0};

        rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'h00);
        check("reset_dz", 32'(div_by_zero), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].d, q, dzo, lat);
            $display("table %0d: %02h / %02h -> %02h dz=%0d lat=%0d", i, tbl[i].a, tbl[i].d, q, dzo, lat);
            check("table_quotient", 32'(q), 32'(tbl[i].q));
            check("table_dz", 32'(dzo), 32'(tbl[i].dz));
            check("table_latency", 32'(lat), 32'd8);
            check("table_busy_at_done", 32'(busy), 32'd0);
        end

        // start re-pulsed at E3 with other operands must be ignored
        dividend = 8'h01;
        divisor  = 8'h53;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        done_at  = 0;
        busy_ok  = 1'b1;
        q_seen   = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k < 8 && !busy) busy_ok = 1'b0;
            if (done) begin
                done_cnt++;
                done_at = k;
                q_seen  = quotient;
            end
            if (k == 2) begin
                start = 1'b1; dividend = 8'h01; divisor = 8'h02;
            end
            if (k == 3) start = 1'b0;
        end
        $display("busy-protect: dones=%0d at=%0d q=%02h", done_cnt, done_at, q_seen);
        check("busyprot_done_count", 32'(done_cnt), 32'd1);
        check("busyprot_done_cycle", 32'(done_at), 32'd8);
        check("busyprot_quotient", 32'(q_seen), 32'hCA);
        check("busyprot_busy_held", 32'(busy_ok), 32'd1);

        // reset at E4 aborts the operation with no done
        dividend = 8'h3C;
        divisor  = 8'h00;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'h00);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        $display("abort: dones after reset=%0d", done_cnt);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(8'h01, 8'h02, q, dzo, lat);
        $display("after abort: 01 / 02 -> %02h lat=%0d", q, lat);
        check("post_abort_quotient", 32'(q), 32'h8D);
        check("post_abort_latency", 32'(lat), 32'd8);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rd;
            ra = 8'($urandom);
            rd = (i % 10 == 9) ? 8'h00 : 8'($urandom);
            run_op(ra, rd, q, dzo, lat);
            $display("random: %02h / %02h -> %02h dz=%0d", ra, rd, q, dzo);
            check("random_quotient", 32'(q), 32'(ref_div(ra, rd)));
            check("random_dz", 32'(dzo), 32'(rd == 8'h00));
            check("random_latency", 32'(lat), 32'd8);
        end

        // back-to-back sweep: start held high, each done cycle accepts the next divisor
        dividend = 8'h01;
        divisor  = 8'h01;
        start    = 1'b1;
        @(posedge clk);
        for (int d = 1; d < 256; d++) begin
            #1;
            check("sweep_busy_after_accept", 32'(busy), 32'd1);
            divisor = 8'(d + 1);
            if (d == 255) start = 1'b0;
            lat = 0;
            q   = 8'hxx;
            dzo = 1'bx;
            while (lat < 20) begin
                @(posedge clk);
                lat++;
                #1;
                if (done) begin
                    q   = quotient;
                    dzo = div_by_zero;
                    break;
                end
            end
            $display("sweep: 01 / %02h -> %02h lat=%0d", d[7:0], q, lat);
            check("sweep_inverse", 32'(ref_mul(q, 8'(d))), 32'h01);
            check("sweep_dz", 32'(dzo), 32'd0);
            check("sweep_period", 32'(lat), 32'd8);
            if (d != 255) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
